load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/load_store_unit_load_formatter.sv | 37 +++
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types, constants and lane helpers for the load/store unit.
// Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b10
  } state_e;

  localparam logic [7:0] LSU_TIMEOUT_CYCLES = 8'd255;

  // Size 2'b11 has no enum member and is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return (size == 2'b11) || ((size == HALF) && offset[0]) ||
           ((size == WORD) && (offset != 2'b00));
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      BYTE:    lane_mask = 4'b0001 << offset;
      HALF:    lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      BYTE:    store_lanes = {4{data[7:0]}};
      HALF:    store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_formatter.sv
`default_nettype none
// ============================================================================
// Module   : load_formatter
// Purpose  : Picks the addressed lane from a memory word and extends it.
// Revision : 1.0  initial release
// ============================================================================
module load_formatter
  import lsu_pkg::*;
(
  input  logic [31:0] loadData,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'b00:   byte_lane = loadData[7:0];
      2'b01:   byte_lane = loadData[15:8];
      2'b10:   byte_lane = loadData[23:16];
      default: byte_lane = loadData[31:24];
    endcase
    half_lane = offset[1] ? loadData[31:16] : loadData[15:0];

    case (size)
      BYTE:    result = {{24{byte_lane[7] & ~unsignedLoad}}, byte_lane};
      HALF:    result = {{16{half_lane[15] & ~unsignedLoad}}, half_lane};
      default: result = loadData;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding load/store bridge between pipeline and memory.
//            Optional wait-state watchdog enabled by macro LSU_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqStore,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respMisaligned,
  output logic        respTimeout,
  output logic [31:0] address,
  output logic [31:0] storeData,
  output logic [3:0]  byteEnable,
  output logic        storeValid,
  input  logic [31:0] loadData,
  input  logic        loadDataValid,
  input  logic        storeComplete
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] store_data_q, store_data_d;
  logic [3:0]  byte_en_q, byte_en_d;
  logic        store_valid_q, store_valid_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_mis_q, resp_mis_d;
  logic [31:0] load_result;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        resp_to_q, resp_to_d;
`endif

  load_formatter u_load_formatter (
    .loadData     (loadData),
    .offset       (addr_q[1:0]),
    .size         (size_q),
    .unsignedLoad (unsigned_q),
    .result       (load_result)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    store_data_d  = store_data_q;
    byte_en_d     = byte_en_q;
    store_valid_d = store_valid_q;
    resp_valid_d  = 1'b0;
    resp_data_d   = resp_data_q;
    resp_mis_d    = 1'b0;
`ifdef LSU_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    resp_to_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (reqValid) begin
          addr_d     = reqAddress;
          size_d     = reqSize;
          unsigned_d = reqUnsigned;
          if (is_misaligned(reqSize, reqAddress[1:0])) begin
            resp_valid_d = 1'b1;
            resp_mis_d   = 1'b1;
            resp_data_d  = '0;
          end else if (reqStore) begin
            state_d       = STORE;
            store_valid_d = 1'b1;
            byte_en_d     = lane_mask(reqSize, reqAddress[1:0]);
            store_data_d  = store_lanes(reqSize, reqData);
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (loadDataValid) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_data_d  = load_result;
        end
      end
      STORE: begin
        if (storeComplete) begin
          state_d       = IDLE;
          store_valid_d = 1'b0;
          byte_en_d     = '0;
          resp_valid_d  = 1'b1;
          resp_data_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef LSU_TIMEOUT_EN
    // Counter is zero on the first waiting cycle; the last allowed cycle forces the exit.
    if (state_q == IDLE) begin
      wait_cnt_d = '0;
    end else if (state_d != IDLE) begin
      if (wait_cnt_q == LSU_TIMEOUT_CYCLES - 8'd1) begin
        state_d       = IDLE;
        store_valid_d = 1'b0;
        byte_en_d     = '0;
        resp_valid_d  = 1'b1;
        resp_to_d     = 1'b1;
        resp_data_d   = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      store_data_q  <= '0;
      byte_en_q     <= '0;
      store_valid_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_mis_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt_q    <= '0;
      resp_to_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      store_data_q  <= store_data_d;
      byte_en_q     <= byte_en_d;
      store_valid_q <= store_valid_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_mis_q    <= resp_mis_d;
`ifdef LSU_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      resp_to_q     <= resp_to_d;
`endif
    end
  end

  assign reqReady       = (state_q == IDLE);
  assign respValid      = resp_valid_q;
  assign respData       = resp_data_q;
  assign respMisaligned = resp_mis_q;
  assign address        = addr_q;
  assign storeData      = store_data_q;
  assign byteEnable     = byte_en_q;
  assign storeValid     = store_valid_q;
`ifdef LSU_TIMEOUT_EN
  assign respTimeout    = resp_to_q;
`else
  assign respTimeout    = 1'b0;
`endif

endmodule
`default_nettype wire
